pixel_plane_sched: RTL and testbench

//  Sequences the 19-plane bit-plane serializer (pixel converter).

---
 rtl/pixel_plane_sched.sv | 155 +++++++++++++++
 tb/tb_pixel_plane_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plane_sched.sv
// Sequencer for the 19-plane bit-plane serializer.
// Round-robin arbitrates cache-line requesters, fires one conv_en per
// granted line, holds gnt/sel steady for the whole burst and spaces the
// start pulses so the serializer's priority chain is never re-triggered.
module pixel_plane_sched #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2,
  parameter int PLANES  = 19,
  parameter int GAP_CYC = 0,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_mask,
  input  logic               cnt_clr,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               conv_en,
  output logic [4:0]         plane_idx,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic [CNT_W-1:0]   bursts_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_BURST,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [3:0]         gap_cnt;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] pick_oh;
  logic [SEL_W-1:0]   pick;
  logic [SEL_W-1:0]   ptr_next;
  logic               found;
  logic               burst_last;

  // Round-robin pick: lowest eligible index at or above ptr, otherwise
  // wrap around to the lowest eligible index overall.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment so
    // no path leaves it unassigned, which would infer a latch.
    elig    = req & req_mask;
    upper   = elig & ({NUM_REQ{1'b1}} << ptr);
    cand    = (upper != '0) ? upper : elig;
    pick    = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand[i] && !found) begin
        pick  = SEL_W'(i);
        found = 1'b1;
      end
    end
    pick_oh    = NUM_REQ'(1) << pick;
    ptr_next   = (pick == SEL_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
    burst_last = (state == S_BURST) && (plane_idx == 5'(PLANES - 1));
  end

  // Burst sequencer with registered outputs and the completed-burst counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      gap_cnt     <= '0;
      ack         <= '0;
      gnt         <= '0;
      sel         <= '0;
      conv_en     <= 1'b0;
      plane_idx   <= '0;
      done        <= '0;
      busy        <= 1'b0;
      bursts_done <= '0;
    end else begin
      conv_en <= 1'b0;
      ack     <= '0;
      done    <= '0;

      case (state)
        S_IDLE: begin
          if (elig != '0) begin
            state     <= S_FIRE;
            ptr       <= ptr_next;
            conv_en   <= 1'b1;
            ack       <= pick_oh;
            gnt       <= pick_oh;
            sel       <= pick;
            plane_idx <= '0;
            busy      <= 1'b1;
          end
        end

        S_FIRE: begin
          state     <= S_BURST;
          plane_idx <= 5'd1;
        end

        S_BURST: begin
          if (burst_last) begin
            state     <= S_DRAIN;
            plane_idx <= '0;
            done      <= gnt;
          end else begin
            plane_idx <= plane_idx + 5'd1;
          end
        end

        S_DRAIN: begin
          gnt <= '0;
          sel <= '0;
          if (GAP_CYC == 0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end

        S_GAP: begin
          if (gap_cnt == 4'(GAP_CYC - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Clear beats a coincident increment on the edge into DRAIN.
      if (cnt_clr) begin
        bursts_done <= '0;
      end else if (burst_last) begin
        bursts_done <= bursts_done + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_plane_sched.sv
// Bench for pixel_plane_sched: two instances (GAP_CYC 0 and 3) share the
// stimulus; a cycle-level model tracks each burst as "cycles since grant"
// and is compared against both every cycle, plus literal scenario checks.
module tb_pixel_plane_sched;

  localparam int PLANES = 19;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'h0;
  logic [3:0] req_mask = 4'hF;
  logic       cnt_clr = 1'b0;

  logic [3:0]  ack_o  [2];
  logic [3:0]  gnt_o  [2];
  logic [3:0]  done_o [2];
  logic [1:0]  sel_o  [2];
  logic        conv_o [2];
  logic        busy_o [2];
  logic [4:0]  pidx_o [2];
  logic [15:0] bd_o   [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  // Model state per instance: active burst, cycles since FIRE, granted index.
  int m_gap    [2] = '{0, 3};
  bit m_active [2] = '{1'b0, 1'b0};
  int m_t      [2] = '{0, 0};
  int m_idx    [2] = '{0, 0};
  int m_ptr    [2] = '{0, 0};
  int m_cnt    [2] = '{0, 0};

  always #5 clk = ~clk;

  pixel_plane_sched #(.GAP_CYC(0)) dut_a (
    .clk(clk), .rst(rst), .req(req), .req_mask(req_mask), .cnt_clr(cnt_clr),
    .ack(ack_o[0]), .gnt(gnt_o[0]), .sel(sel_o[0]), .conv_en(conv_o[0]),
    .plane_idx(pidx_o[0]), .done(done_o[0]), .busy(busy_o[0]),
    .bursts_done(bd_o[0])
  );

  pixel_plane_sched #(.GAP_CYC(3)) dut_b (
    .clk(clk), .rst(rst), .req(req), .req_mask(req_mask), .cnt_clr(cnt_clr),
    .ack(ack_o[1]), .gnt(gnt_o[1]), .sel(sel_o[1]), .conv_en(conv_o[1]),
    .plane_idx(pidx_o[1]), .done(done_o[1]), .busy(busy_o[1]),
    .bursts_done(bd_o[1])
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] elig, input int ptr);
    for (int i = 0; i < 4; i++) begin
      if (elig[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return 0;
  endfunction

  // Reference model: advance one clock using the pre-edge inputs.
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_active[k] = 1'b0;
        m_t[k]      = 0;
        m_ptr[k]    = 0;
        m_cnt[k]    = 0;
      end else begin
        if (cnt_clr) m_cnt[k] = 0;
        else if (m_active[k] && m_t[k] == PLANES - 1) m_cnt[k] = (m_cnt[k] + 1) % 65536;
        if (m_active[k]) begin
          if (m_t[k] == PLANES + m_gap[k]) m_active[k] = 1'b0;
          else m_t[k] = m_t[k] + 1;
        end else if ((req & req_mask) != 4'h0) begin
          m_idx[k]    = rr_pick(req & req_mask, m_ptr[k]);
          m_ptr[k]    = (m_idx[k] + 1) % 4;
          m_t[k]      = 0;
          m_active[k] = 1'b1;
        end
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    logic [3:0] oh;
    int         t;
    bit         a;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        a  = m_active[k];
        t  = m_t[k];
        oh = 4'(1 << m_idx[k]);
        check($sformatf("conv_en[%0d]", k), 32'(conv_o[k]), 32'(a && t == 0));
        check($sformatf("ack[%0d]", k), 32'(ack_o[k]), (a && t == 0) ? 32'(oh) : 32'h0);
        check($sformatf("gnt[%0d]", k), 32'(gnt_o[k]), (a && t <= PLANES) ? 32'(oh) : 32'h0);
        check($sformatf("sel[%0d]", k), 32'(sel_o[k]), (a && t <= PLANES) ? 32'(m_idx[k]) : 32'h0);
        check($sformatf("plane_idx[%0d]", k), 32'(pidx_o[k]), (a && t < PLANES) ? 32'(t) : 32'h0);
        check($sformatf("done[%0d]", k), 32'(done_o[k]), (a && t == PLANES) ? 32'(oh) : 32'h0);
        check($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(a));
        check($sformatf("bursts_done[%0d]", k), 32'(bd_o[k]), 32'(m_cnt[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = 4'h0;
    req_mask = 4'hF;
    cnt_clr  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_conv(input int k, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (conv_o[k] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    int last;
    int n;

    // Single requester: timing of FIRE, DRAIN and return to IDLE.
    do_reset();
    chk_en = 1'b1;
    req = 4'b0001;
    tick();
    check("t1_conv_en", 32'(conv_o[0]), 32'h1);
    check("t1_ack", 32'(ack_o[0]), 32'h1);
    req = 4'b0000;
    repeat (19) tick();
    check("t1_done", 32'(done_o[0]), 32'h1);
    check("t1_bursts_done", 32'(bd_o[0]), 32'h1);
    tick();
    check("t1_busy_low", 32'(busy_o[0]), 32'h0);
    repeat (5) tick();

    // All requesting: grant order 0,1,2,3,0 at 21-cycle spacing.
    do_reset();
    req  = 4'b1111;
    last = 0;
    for (int i = 0; i < 5; i++) begin
      wait_conv(0, 30, found);
      check("t2_conv_seen", 32'(found), 32'h1);
      check("t2_order", 32'(sel_o[0]), 32'(i % 4));
      if (i > 0) check("t2_spacing", 32'(cyc - last), 32'd21);
      last = cyc;
    end
    req = 4'b0000;
    repeat (25) tick();

    // ptr=2 after a grant to 1: req 1010 grants 3 then 1; sel=3 for 20 cycles.
    do_reset();
    req = 4'b0010;
    wait_conv(0, 5, found);
    check("t3_first_seen", 32'(found), 32'h1);
    check("t3_first_sel", 32'(sel_o[0]), 32'd1);
    req = 4'b0000;
    repeat (25) tick();
    req = 4'b1010;
    wait_conv(0, 5, found);
    check("t3_second_seen", 32'(found), 32'h1);
    check("t3_second_sel", 32'(sel_o[0]), 32'd3);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sel_o[0] == 2'd3 && gnt_o[0] == 4'b1000) n++;
    end
    check("t3_sel_hold_len", 32'(n), 32'd20);
    wait_conv(0, 5, found);
    check("t3_third_seen", 32'(found), 32'h1);
    check("t3_third_sel", 32'(sel_o[0]), 32'd1);
    req = 4'b0000;
    repeat (25) tick();

    // Masked requester is never granted until the mask opens.
    do_reset();
    req_mask = 4'b0111;
    req      = 4'b1000;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (conv_o[0] || conv_o[1]) n++;
    end
    check("t4_no_conv", 32'(n), 32'h0);
    req_mask = 4'hF;
    wait_conv(0, 5, found);
    check("t4_conv_seen", 32'(found), 32'h1);
    check("t4_sel", 32'(sel_o[0]), 32'd3);
    req = 4'b0000;
    repeat (25) tick();

    // GAP_CYC=3 instance: gnt low through the gap, spacing 24.
    do_reset();
    req = 4'b1111;
    wait_conv(1, 5, found);
    check("t5_first_seen", 32'(found), 32'h1);
    last = cyc;
    repeat (19) tick();
    check("t5_done", 32'(done_o[1]), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_gap_gnt", 32'(gnt_o[1]), 32'h0);
      check("t5_gap_busy", 32'(busy_o[1]), 32'h1);
    end
    wait_conv(1, 5, found);
    check("t5_second_seen", 32'(found), 32'h1);
    check("t5_spacing", 32'(cyc - last), 32'd24);
    req = 4'b0000;
    repeat (30) tick();

    // Reset at T+10 aborts the burst; pending req re-granted from ptr=0.
    do_reset();
    req = 4'b0110;
    wait_conv(0, 5, found);
    check("t6_seen", 32'(found), 32'h1);
    check("t6_sel", 32'(sel_o[0]), 32'd1);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_gnt", 32'(gnt_o[0]), 32'h0);
    check("t6_rst_busy", 32'(busy_o[0]), 32'h0);
    check("t6_rst_done", 32'(done_o[0]), 32'h0);
    check("t6_rst_pidx", 32'(pidx_o[0]), 32'h0);
    wait_conv(0, 5, found);
    check("t6_regrant_seen", 32'(found), 32'h1);
    check("t6_regrant_sel", 32'(sel_o[0]), 32'd1);
    req = 4'b0000;
    repeat (30) tick();

    // cnt_clr coinciding with the DRAIN increment leaves the count at 0.
    do_reset();
    req = 4'b0001;
    wait_conv(0, 5, found);
    check("t7_seen", 32'(found), 32'h1);
    req = 4'b0000;
    repeat (18) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("t7_done", 32'(done_o[0]), 32'h1);
    check("t7_count_cleared", 32'(bd_o[0]), 32'h0);
    repeat (25) tick();

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      req      = 4'($urandom_range(0, 15));
      req_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      cnt_clr  = ($urandom_range(0, 63) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst     = 1'b0;
    cnt_clr = 1'b0;
    req     = 4'h0;
    repeat (30) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
